// File: rtl/line_wr_buf.sv
// line_wr_buf -- single-clock video line write buffer.
//
// Packs incoming pixels LSB-first into 8*DQ_WIDTH-bit memory words, stores
// each line in one half of a ping-pong two-line buffer, and hands every
// completed line to the DDR write controller as one burst (address + length
// command, then show-ahead data beats).  A one-cycle interrupt fires when
// the last line of a frame has been written.
//
// Optional build macro:
//   LINE_WR_BUF_FRAME_WRAP4_EN  frame_wcnt counts 0,1,2,3,0,... (upper bits 0)
//                               instead of wrapping at 2^FRAME_CNT_WIDTH.
//
// Ports:
//   ddr_clk        sole clock, rising edge
//   ddr_rstn       synchronous active-low reset
//   wr_fsync       frame sync level; rising edge restarts the frame
//   wr_en/wr_data  pixel valid / pixel
//   rd_bac         burst-accepted pulse (no functional effect)
//   ddr_wreq       write command request (high while waiting for ddr_wrdy)
//   ddr_waddr      command address = ADDR_OFFSET + {frame, line*LSTEP}
//   ddr_wr_len     burst length in memory words
//   ddr_wrdy       command accepted
//   ddr_wdone      command complete pulse
//   ddr_wdata      data word at the read pointer (show-ahead)
//   ddr_wdata_req  beat consumed this cycle
//   frame_wcnt     current frame index
//   frame_wirq     one-cycle frame-written pulse
module line_wr_buf #(
  parameter int ADDR_WIDTH      = 28,
  parameter int ADDR_OFFSET     = 0,
  parameter int H_NUM           = 640,
  parameter int V_NUM           = 720,
  parameter int DQ_WIDTH        = 32,
  parameter int LEN_WIDTH       = 32,
  parameter int PIX_WIDTH       = 16,
  parameter int LINE_ADDR_WIDTH = 22,
  parameter int FRAME_CNT_WIDTH = ADDR_WIDTH - LINE_ADDR_WIDTH
) (
  input  logic                       ddr_clk,
  input  logic                       ddr_rstn,
  input  logic                       wr_fsync,
  input  logic                       wr_en,
  input  logic [PIX_WIDTH-1:0]       wr_data,
  input  logic                       rd_bac,
  output logic                       ddr_wreq,
  output logic [ADDR_WIDTH-1:0]      ddr_waddr,
  output logic [LEN_WIDTH-1:0]       ddr_wr_len,
  input  logic                       ddr_wrdy,
  input  logic                       ddr_wdone,
  output logic [8*DQ_WIDTH-1:0]      ddr_wdata,
  input  logic                       ddr_wdata_req,
  output logic [FRAME_CNT_WIDTH-1:0] frame_wcnt,
  output logic                       frame_wirq
);

  localparam int DW     = 8 * DQ_WIDTH;
  localparam int PPW    = DW / PIX_WIDTH;
  localparam int LWORDS = H_NUM * PIX_WIDTH / DW;
  localparam int LSTEP  = H_NUM * PIX_WIDTH / DQ_WIDTH;
  localparam int KW     = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int WW     = (LWORDS > 1) ? $clog2(LWORDS) : 1;
  localparam int LW     = $clog2(V_NUM + 1);

  localparam logic [KW-1:0] LAST_K = KW'(PPW - 1);
  localparam logic [WW-1:0] LAST_W = WW'(LWORDS - 1);
  localparam logic [LW-1:0] LAST_L = LW'(V_NUM - 1);
  localparam logic [LW-1:0] END_L  = LW'(V_NUM);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_WAIT} state_t;

  // Per-bank command descriptor, latched when the line completes.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  last;   // line V_NUM-1 of the frame
  } line_desc_t;

  // ---------------------------------------------------------------- storage
  logic [DW-1:0] mem [2][LWORDS];
  line_desc_t    desc [2];

  // ---------------------------------------------------------------- fill side
  logic          fsync_q;
  logic [KW-1:0] kcnt;
  logic [WW-1:0] wptr;
  logic [LW-1:0] line_idx;
  logic [DW-1:0] pack;
  logic          fill_bank;
  logic          line_drop;   // current line is being discarded (no bank)
  logic [1:0]    pending;
  logic          oldest;      // bank that became pending first

  // ---------------------------------------------------------------- drain side
  state_t        state, state_nxt;
  logic          xbank;
  logic [WW-1:0] rd_ptr;
  logic          done_seen;
  logic [FRAME_CNT_WIDTH-1:0] fcnt_next;

  // ---------------------------------------------------------------- comb
  logic                       fsync_rise, pix_ok, word_done, line_done;
  logic                       at_line_start, free, pick;
  logic [1:0]                 free_vec, set_vec, pend_cur, pend_next;
  logic                       fill_nxt, drop_nxt;
  logic [DW-1:0]              pack_next;
  logic [LINE_ADDR_WIDTH-1:0] line_off;
  logic [ADDR_WIDTH-1:0]      line_addr;
  logic                       unused;

  assign unused = rd_bac;

  assign fsync_rise    = wr_fsync & ~fsync_q;
  assign pix_ok        = wr_en & ~fsync_rise & (line_idx < END_L);
  assign word_done     = pix_ok & (kcnt == LAST_K);
  assign line_done     = word_done & (wptr == LAST_W);
  assign at_line_start = (kcnt == '0) && (wptr == '0);

  always_comb begin
    pack_next = pack;
    pack_next[int'(kcnt)*PIX_WIDTH +: PIX_WIDTH] = wr_data;
  end

  assign line_off  = LINE_ADDR_WIDTH'(int'(line_idx) * LSTEP);
  assign line_addr = ADDR_WIDTH'(ADDR_OFFSET) + ADDR_WIDTH'({frame_wcnt, line_off});

  // A bank freed this cycle already counts as empty for the fill side.
  assign free      = (state == S_WAIT) && (ddr_wdone || done_seen);
  assign free_vec  = free ? (2'b01 << xbank) : 2'b00;
  assign pend_cur  = pending & ~free_vec;
  assign set_vec   = (line_done && !line_drop) ? (2'b01 << fill_bank) : 2'b00;
  assign pend_next = pend_cur | set_vec;

  // Choose the bank for the next line: keep the current one if it is free,
  // else move to the other one, else drop the line until a bank frees up.
  always_comb begin
    fill_nxt = fill_bank;
    drop_nxt = 1'b0;
    if (pend_next[fill_bank]) begin
      if (!pend_next[~fill_bank]) fill_nxt = ~fill_bank;
      else                        drop_nxt = 1'b1;
    end
  end

  // ---------------------------------------------------------------- fill regs
  always_ff @(posedge ddr_clk) begin
    if (!ddr_rstn) begin
      fsync_q   <= 1'b0;
      kcnt      <= '0;
      wptr      <= '0;
      line_idx  <= '0;
      pack      <= '0;
      fill_bank <= 1'b0;
      line_drop <= 1'b0;
      pending   <= 2'b00;
      oldest    <= 1'b0;
      desc[0]   <= '0;
      desc[1]   <= '0;
    end else begin
      fsync_q <= wr_fsync;
      pending <= pend_next;
      if ((set_vec != 2'b00) && !pend_cur[~fill_bank]) oldest <= fill_bank;
      if (line_done && !line_drop) begin
        desc[fill_bank].addr <= line_addr;
        desc[fill_bank].last <= (line_idx == LAST_L);
      end
      // Bank choice is re-evaluated between lines so a line that was
      // blocked by two pending banks can resume once one drains.
      if (fsync_rise || line_done || at_line_start) begin
        fill_bank <= fill_nxt;
        line_drop <= drop_nxt;
      end
      if (fsync_rise) begin
        kcnt     <= '0;
        wptr     <= '0;
        line_idx <= '0;
      end else if (pix_ok) begin
        pack <= pack_next;
        kcnt <= word_done ? '0 : kcnt + 1'b1;
        if (word_done) wptr <= line_done ? '0 : wptr + 1'b1;
        if (line_done) line_idx <= line_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge ddr_clk) begin
    if (word_done && !line_drop) mem[fill_bank][wptr] <= pack_next;
  end

  // ---------------------------------------------------------------- drain FSM
  assign pick = (pending == 2'b11) ? oldest : pending[1];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (|pending)                              state_nxt = S_REQ;
      S_REQ:  if (ddr_wrdy)                              state_nxt = S_DATA;
      S_DATA: if (ddr_wdata_req && (rd_ptr == LAST_W))   state_nxt = S_WAIT;
      S_WAIT: if (ddr_wdone || done_seen)                state_nxt = S_IDLE;
      default:                                           state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    fcnt_next = frame_wcnt + 1'b1;
`ifdef LINE_WR_BUF_FRAME_WRAP4_EN
    fcnt_next      = '0;
    fcnt_next[1:0] = frame_wcnt[1:0] + 2'd1;
`endif
  end

  always_ff @(posedge ddr_clk) begin
    if (!ddr_rstn) begin
      state      <= S_IDLE;
      xbank      <= 1'b0;
      rd_ptr     <= '0;
      done_seen  <= 1'b0;
      ddr_waddr  <= '0;
      ddr_wr_len <= '0;
      frame_wcnt <= '0;
      frame_wirq <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_wirq <= 1'b0;
      case (state)
        S_IDLE: if (|pending) begin
          xbank      <= pick;
          ddr_waddr  <= desc[pick].addr;
          ddr_wr_len <= LEN_WIDTH'(LWORDS);
        end
        S_REQ: begin
          rd_ptr    <= '0;
          done_seen <= 1'b0;
        end
        S_DATA: begin
          if (ddr_wdata_req) rd_ptr <= rd_ptr + 1'b1;
          // Early completion is held until the last beat has gone out.
          if (ddr_wdone) done_seen <= 1'b1;
        end
        S_WAIT: if (free) begin
          done_seen <= 1'b0;
          if (desc[xbank].last) begin
            frame_wirq <= 1'b1;
            frame_wcnt <= fcnt_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign ddr_wreq  = (state == S_REQ);
  assign ddr_wdata = (state == S_DATA) ? mem[xbank][rd_ptr] : '0;

endmodule

// File: tb/tb_line_wr_buf.sv
// Directed bench for line_wr_buf. V_NUM is reduced to 4 lines per frame so
// several full frames fit in a short run; line geometry keeps the defaults
// (640 pixels, 40 words of 256 bits, line step 320).
module tb_line_wr_buf;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         wr_fsync = 1'b0;
  logic         wr_en = 1'b0;
  logic [15:0]  wr_data = '0;
  logic         ddr_wreq;
  logic [27:0]  ddr_waddr;
  logic [31:0]  ddr_wr_len;
  logic         ddr_wrdy = 1'b0;
  logic         ddr_wdone = 1'b0;
  logic [255:0] ddr_wdata;
  logic         ddr_wdata_req = 1'b0;
  logic [5:0]   frame_wcnt;
  logic         frame_wirq;

  line_wr_buf #(.V_NUM(4)) dut (
    .ddr_clk(clk), .ddr_rstn(rstn), .wr_fsync(wr_fsync), .wr_en(wr_en),
    .wr_data(wr_data), .rd_bac(1'b0), .ddr_wreq(ddr_wreq),
    .ddr_waddr(ddr_waddr), .ddr_wr_len(ddr_wr_len), .ddr_wrdy(ddr_wrdy),
    .ddr_wdone(ddr_wdone), .ddr_wdata(ddr_wdata),
    .ddr_wdata_req(ddr_wdata_req), .frame_wcnt(frame_wcnt),
    .frame_wirq(frame_wirq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int xi    = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------- controller model
  logic [27:0]  addr_q[$];
  logic [31:0]  len_q[$];
  logic [255:0] words_q[$];
  int  c_state = 0, beat = 0, done_cnt = 0;
  bit  ctl_ready = 1'b1, ctl_early = 1'b0, cur_early = 1'b0;

  always @(negedge clk) begin
    ddr_wdone = 1'b0;
    if (!rstn) begin
      ddr_wrdy = 1'b0; ddr_wdata_req = 1'b0; c_state = 0;
    end else if (c_state == 0) begin
      ddr_wdata_req = 1'b0;
      ddr_wrdy = 1'b0;
      if (ddr_wreq && ctl_ready) begin
        ddr_wrdy = 1'b1;
        addr_q.push_back(ddr_waddr);
        len_q.push_back(ddr_wr_len);
        beat = 0; c_state = 1; cur_early = ctl_early;
      end
    end else begin
      ddr_wrdy = 1'b0;
      if (beat < 40) begin
        words_q.push_back(ddr_wdata);
        ddr_wdata_req = 1'b1;
        beat++;
        if (cur_early && beat == 20) ddr_wdone = 1'b1;
      end else begin
        ddr_wdata_req = 1'b0;
        if (!cur_early) ddr_wdone = 1'b1;
        done_cnt++;
        c_state = 0;
      end
    end
  end

  // ---------------------------------------------------------- irq monitor
  bit         irq_prev = 1'b0;
  int         irq_cnt = 0, irq_wide = 0;
  logic [5:0] wcnt_q[$];

  always @(negedge clk) begin
    if (frame_wirq === 1'b1) begin
      irq_cnt++;
      wcnt_q.push_back(frame_wcnt);
      if (irq_prev) irq_wide++;
    end
    irq_prev = (frame_wirq === 1'b1);
  end

  // ---------------------------------------------------------- helpers
  function automatic logic [255:0] exp_word(input int base, input int j);
    logic [255:0] w;
    for (int s = 0; s < 16; s++) w[s*16 +: 16] = 16'(base + 16*j + s);
    return w;
  endfunction

  task automatic send_pixels(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = 16'(base + i);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic send_line(input int base);
    send_pixels(base, 640);
  endtask

  task automatic fsync_pulse();
    @(negedge clk); wr_fsync = 1'b1;
    @(negedge clk); wr_fsync = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int n);
    int t = 0;
    while (done_cnt < n && t < 6000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " timeout"}, 256'(done_cnt >= n), 256'(1));
  endtask

  task automatic check_xfer(input string tag, input logic [27:0] eaddr, input int base);
    int nbad = 0;
    chk({tag, " seen"}, 256'(addr_q.size() > xi), 256'(1));
    if (addr_q.size() > xi) begin
      chk({tag, " addr"}, addr_q[xi], eaddr);
      chk({tag, " len"}, len_q[xi], 256'(40));
      for (int j = 0; j < 40; j++)
        if (words_q.size() <= xi*40 + j || words_q[xi*40 + j] !== exp_word(base, j)) nbad++;
      chk({tag, " data"}, nbad, 0);
    end
    xi++;
  endtask

  // ---------------------------------------------------------- sequence
  initial begin
    int exp_w;

    // reset
    repeat (3) @(negedge clk);
    chk("rst wreq", ddr_wreq, 0);
    chk("rst waddr", ddr_waddr, 0);
    chk("rst wr_len", ddr_wr_len, 0);
    chk("rst wdata", ddr_wdata, 0);
    chk("rst wcnt", frame_wcnt, 0);
    chk("rst wirq", frame_wirq, 0);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle wreq", ddr_wreq, 0);
    chk("idle no cmd", addr_q.size(), 0);

    // frame 0: four lines, first with pixel value = index
    fsync_pulse();
    send_line(0);
    wait_done("f0l0", 1);
    check_xfer("f0l0", 28'h0, 0);
    chk("f0l0 w0 lo", words_q[0][15:0], 16'd0);
    chk("f0l0 w0 hi", words_q[0][255:240], 16'd15);
    ctl_early = 1'b1;
    send_line(1000);
    wait_done("f0l1", 2);
    ctl_early = 1'b0;
    check_xfer("f0l1", 28'd320, 1000);
    chk("no irq yet", irq_cnt, 0);
    send_line(2000);
    send_line(3000);
    wait_done("f0l3", 4);
    repeat (5) @(negedge clk);
    check_xfer("f0l2", 28'd640, 2000);
    check_xfer("f0l3", 28'd960, 3000);
    chk("f0 irq cnt", irq_cnt, 1);
    chk("f0 irq width", irq_wide, 0);
    chk("f0 wcnt", frame_wcnt, 1);

    // pixels past the last line are ignored until the next fsync
    send_line(4000);
    repeat (200) @(negedge clk);
    chk("past end no xfer", done_cnt, 4);
    chk("past end no cmd", addr_q.size(), 4);

    // frame 1 line 0 carries the new frame index
    fsync_pulse();
    send_line(5000);
    wait_done("f1l0", 5);
    check_xfer("f1l0", 28'h400000, 5000);

    // restart frame 1 with the controller stalled: third line is dropped
    fsync_pulse();
    ctl_ready = 1'b0;
    send_line(6000);
    send_line(7000);
    send_line(8000);
    repeat (1100) @(negedge clk);
    chk("stall no xfer", done_cnt, 5);
    chk("stall wreq held", ddr_wreq, 1);
    ctl_ready = 1'b1;
    wait_done("ovf", 7);
    repeat (100) @(negedge clk);
    chk("ovf drop", done_cnt, 7);
    check_xfer("ovf l0", 28'h400000, 6000);
    check_xfer("ovf l1", 28'h400140, 7000);
    send_line(9000);
    wait_done("ovf l3", 8);
    repeat (5) @(negedge clk);
    check_xfer("ovf l3", 28'h4003C0, 9000);
    chk("f1 irq cnt", irq_cnt, 2);

    // fsync mid-line discards the partial line
    fsync_pulse();
    send_pixels(12345, 100);
    fsync_pulse();
    send_line(10000);
    wait_done("midsync", 9);
    check_xfer("midsync", 28'h800000, 10000);

    // finish this frame plus two more
    send_line(11000);
    send_line(12000);
    send_line(13000);
    for (int f = 0; f < 2; f++) begin
      fsync_pulse();
      for (int l = 0; l < 4; l++) send_line(20000 + 1000*l);
    end
    wait_done("frames", 20);
    repeat (5) @(negedge clk);
    chk("total xfers", done_cnt, 20);
    chk("irq total", irq_cnt, 5);
    chk("irq width", irq_wide, 0);
    chk("wcnt seq len", wcnt_q.size(), 5);
    for (int k = 0; k < 5; k++) begin
`ifdef LINE_WR_BUF_FRAME_WRAP4_EN
      exp_w = (k + 1) % 4;
`else
      exp_w = k + 1;
`endif
      chk($sformatf("wcnt seq %0d", k), (wcnt_q.size() > k) ? wcnt_q[k] : 6'h3f, 6'(exp_w));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
